// File: rtl/mips_multicycle_pkg.sv
// Shared types and constants for the mips_multicycle core.
// Opcodes, functs, FSM states and instruction field positions.
`timescale 1ns/1ps
package mips_multicycle_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_ADDI  = 4'd1;
    localparam logic [3:0] OP_LW    = 4'd2;
    localparam logic [3:0] OP_SW    = 4'd3;
    localparam logic [3:0] OP_BEQ   = 4'd4;
    localparam logic [3:0] OP_J     = 4'd5;
    localparam logic [3:0] OP_HALT  = 4'd6;

    localparam logic [2:0] F_ADD = 3'd0;
    localparam logic [2:0] F_SUB = 3'd1;
    localparam logic [2:0] F_AND = 3'd2;
    localparam logic [2:0] F_OR  = 3'd3;
    localparam logic [2:0] F_SLT = 3'd4;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RS_MSB  = 11;
    localparam int RS_LSB  = 9;
    localparam int RT_MSB  = 8;
    localparam int RT_LSB  = 6;
    localparam int RD_MSB  = 5;
    localparam int RD_LSB  = 3;
    localparam int FN_MSB  = 2;
    localparam int FN_LSB  = 0;
    localparam int IMM_MSB = 5;
    localparam int JT_MSB  = 11;

endpackage

// File: rtl/mips_multicycle_if.sv
// Unified instruction/data memory port with valid/ready handshake.
// The core is the master; the memory system is the slave.
`timescale 1ns/1ps
interface mips_multicycle_if #(
    parameter int AWIDTH = 16,
    parameter int DWIDTH = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wdata;
    logic [DWIDTH-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mips_mc_regfile.sv
// 8-entry register file, two async reads, one sync write.
// r0 always reads zero and ignores writes.
`timescale 1ns/1ps
module mips_mc_regfile #(
    parameter int DWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        ra1,
    input  logic [2:0]        ra2,
    output logic [DWIDTH-1:0] rd1,
    output logic [DWIDTH-1:0] rd2,
    input  logic              we,
    input  logic [2:0]        wa,
    input  logic [DWIDTH-1:0] wd
);
    logic [DWIDTH-1:0] regs [0:7];

    // write port; r0 is never written so it stays at its reset value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (we && (wa != 3'd0)) begin
            regs[wa] <= wd;
        end
    end

    // async read ports with r0 forced to zero
    always_comb begin
        rd1 = (ra1 == 3'd0) ? '0 : regs[ra1];
        rd2 = (ra2 == 3'd0) ? '0 : regs[ra2];
    end
endmodule

// File: rtl/mips_multicycle.sv
// Multicycle MIPS-style core: FSM, ALU and datapath registers.
// One shared memory port serves both fetch and load/store.
`timescale 1ns/1ps
module mips_multicycle
    import mips_multicycle_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    mips_multicycle_if.master  mem,
    output logic [AWIDTH-1:0]  pc,
    output logic               halted,
    output logic               illegal
);
    state_t state, state_nx;

    logic [15:0]       ir;
    logic [DWIDTH-1:0] a_q, b_q, alu_q, mdr;
    logic [DWIDTH-1:0] rd_a, rd_b, alu_y, imm_d, rf_wd;
    logic [AWIDTH-1:0] imm_a, jmp_pc;
    logic [3:0]        op;
    logic [2:0]        rs, rt, rd, funct, rf_wa;
    logic [11:0]       jt;
    logic              bad_op, xfer, rf_we;

    assign op    = ir[OP_MSB:OP_LSB];
    assign rs    = ir[RS_MSB:RS_LSB];
    assign rt    = ir[RT_MSB:RT_LSB];
    assign rd    = ir[RD_MSB:RD_LSB];
    assign funct = ir[FN_MSB:FN_LSB];
    assign jt    = ir[JT_MSB:0];
    assign imm_d = {{(DWIDTH-6){ir[IMM_MSB]}}, ir[IMM_MSB:0]};
    assign imm_a = {{(AWIDTH-6){ir[IMM_MSB]}}, ir[IMM_MSB:0]};
    assign xfer  = mem.mem_req & mem.mem_ready;

    assign bad_op = (op > OP_HALT) ||
                    ((op == OP_RTYPE) && (funct > F_SLT));

    assign rf_we = (state == S_WB);
    assign rf_wa = (op == OP_RTYPE) ? rd : rt;
    assign rf_wd = (op == OP_LW) ? mdr : alu_q;

    mips_mc_regfile #(.DWIDTH(DWIDTH)) u_rf (
        .clk   (clk),
        .rst_n (reset),
        .ra1   (rs),
        .ra2   (rt),
        .rd1   (rd_a),
        .rd2   (rd_b),
        .we    (rf_we),
        .wa    (rf_wa),
        .wd    (rf_wd)
    );

    // jump keeps the pc page and replaces the low 12 bits
    always_comb begin
        jmp_pc = pc;
        jmp_pc[11:0] = jt;
    end

    // ALU: R-type uses B, everything else adds the immediate
    always_comb begin
        alu_y = a_q + imm_d;
        if (op == OP_RTYPE) begin
            case (funct)
                F_SUB:   alu_y = a_q - b_q;
                F_AND:   alu_y = a_q & b_q;
                F_OR:    alu_y = a_q | b_q;
                F_SLT:   alu_y = DWIDTH'($signed(a_q) < $signed(b_q));
                default: alu_y = a_q + b_q;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= state_nx;
    end

    // FSM next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            S_FETCH:  if (xfer) state_nx = S_DECODE;
            S_DECODE: begin
                unique case (1'b1)
                    bad_op:          state_nx = S_HALT;
                    (op == OP_J):    state_nx = S_FETCH;
                    (op == OP_HALT): state_nx = S_HALT;
                    default:         state_nx = S_EXEC;
                endcase
            end
            S_EXEC: begin
                unique case (1'b1)
                    (op == OP_BEQ):              state_nx = S_FETCH;
                    (op == OP_LW || op == OP_SW): state_nx = S_MEM;
                    default:                     state_nx = S_WB;
                endcase
            end
            S_MEM: if (xfer) state_nx = (op == OP_LW) ? S_WB : S_FETCH;
            S_WB:     state_nx = S_FETCH;
            default:  state_nx = S_HALT;
        endcase
    end

    // FSM outputs; reset gates mem_req so it drops asynchronously
    always_comb begin
        mem.mem_req   = reset && ((state == S_FETCH) || (state == S_MEM));
        mem.mem_we    = mem.mem_req && (state == S_MEM) && (op == OP_SW);
        mem.mem_addr  = (state == S_MEM) ? AWIDTH'(alu_q) : pc;
        mem.mem_wdata = mem.mem_we ? b_q : '0;
        halted        = (state == S_HALT);
    end

    // datapath registers updated per FSM state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc      <= '0;
            ir      <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr     <= '0;
            illegal <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (xfer) begin
                        ir <= mem.mem_rdata[15:0];
                        pc <= pc + AWIDTH'(1);
                    end
                end
                S_DECODE: begin
                    a_q <= rd_a;
                    b_q <= rd_b;
                    if (bad_op)
                        illegal <= 1'b1;
                    else if (op == OP_J)
                        pc <= jmp_pc;
                end
                S_EXEC: begin
                    alu_q <= alu_y;
                    if ((op == OP_BEQ) && (a_q == b_q))
                        pc <= pc + imm_a;
                end
                S_MEM: begin
                    if (xfer && (op == OP_LW))
                        mdr <= mem.mem_rdata;
                end
                default: ;
            endcase
        end
    end
endmodule
